// File: rtl/leitor_display_pkg.sv
// leitor_display_pkg: shared constants for the seven-segment read-back checker
// Segment patterns use bit0=A .. bit6=G, active-high.
package leitor_display_pkg;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_9_ALT = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] DIG_INVALIDO = 4'hF;
  localparam int SLOT_UNI = 0;
  localparam int SLOT_DEZ = 1;
  localparam int SLOT_CEN = 2;
  function automatic logic um_quente(input logic [2:0] d);
    return (d != 3'b000) && ((d & (d - 3'd1)) == 3'b000);
  endfunction
endpackage

// File: rtl/decodificador_7seg.sv
// decodificador_7seg: combinational seven-segment pattern to BCD digit
// Ports: seg (7-bit pattern in), digito (BCD out, DIG_INVALIDO if unknown),
//        invalido (pattern not in the decode table).
module decodificador_7seg
  import leitor_display_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digito,
  output logic       invalido
);
  always_comb begin
    digito = DIG_INVALIDO;
    case (seg)
      SEG_0:            digito = 4'd0;
      SEG_1:            digito = 4'd1;
      SEG_2:            digito = 4'd2;
      SEG_3:            digito = 4'd3;
      SEG_4:            digito = 4'd4;
      SEG_5:            digito = 4'd5;
      SEG_6:            digito = 4'd6;
      SEG_7:            digito = 4'd7;
      SEG_8:            digito = 4'd8;
      SEG_9, SEG_9_ALT: digito = 4'd9;
      default:          digito = DIG_INVALIDO;
    endcase
  end
  assign invalido = digito == DIG_INVALIDO;
endmodule

// File: rtl/leitor_display.sv
// leitor_display: recovers the 3-digit number shown on a multiplexed 7-seg bus
// Ports: clk, rst_n (async active-low), seg[6:0], dig_sel[2:0] (one-hot strobe),
//        valor_bcd[11:0] {cen,dez,uni}, valor_bin[9:0], pronto (publish pulse),
//        erro (published frame had an undecodable digit).
// Build option: LEITOR_BIN_EN enables the BCD-to-binary conversion; without it
// valor_bin is tied to 0.
module leitor_display
  import leitor_display_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [2:0]  dig_sel,
  output logic [11:0] valor_bcd,
  output logic [9:0]  valor_bin,
  output logic        pronto,
  output logic        erro
);
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);
  logic [6:0]  seg_q;
  logic [2:0]  dig_q;
  logic [7:0]  cnt;
  logic [11:0] digitos;
  logic [2:0]  inv;
  logic [2:0]  mask;
  logic [3:0]  digito;
  logic        d_inv;
  logic        igual;
  logic        captura;
  logic        publica;
  logic [2:0]  cap_bits;
  decodificador_7seg u_dec (
    .seg      (seg_q),
    .digito   (digito),
    .invalido (d_inv)
  );
  assign igual    = (seg == seg_q) && (dig_sel == dig_q);
  // Fires on the edge the counter steps into CNT_MAX; saturation keeps it to one per run.
  assign captura  = igual && (cnt == CNT_CAP) && um_quente(dig_q) && (seg_q != SEG_BLANK);
  assign cap_bits = captura ? dig_q : 3'b000;
  assign publica  = mask == 3'b111;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= '0;
      dig_q     <= '0;
      cnt       <= '0;
      digitos   <= '0;
      inv       <= '0;
      mask      <= '0;
      valor_bcd <= '0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
    end else begin
      seg_q  <= seg;
      dig_q  <= dig_sel;
      cnt    <= !igual ? 8'd0 : (cnt == CNT_MAX ? cnt : cnt + 8'd1);
      pronto <= publica;
      if (publica) begin
        valor_bcd <= digitos;
        erro      <= |inv;
      end
      // Clear on publish first, so a same-edge capture lands in the next frame.
      mask <= (publica ? 3'b000 : mask) | cap_bits;
      inv  <= ((publica ? 3'b000 : inv) & ~cap_bits) | (d_inv ? cap_bits : 3'b000);
      for (int i = 0; i < 3; i++)
        if (cap_bits[i]) digitos[i*4 +: 4] <= digito;
    end
  end
`ifdef LEITOR_BIN_EN
  logic [9:0] bin_calc;
  assign bin_calc = (|inv) ? 10'd0 :
                    10'(digitos[SLOT_CEN*4 +: 4]) * 10'd100 +
                    10'(digitos[SLOT_DEZ*4 +: 4]) * 10'd10 +
                    10'(digitos[SLOT_UNI*4 +: 4]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valor_bin <= '0;
    else if (publica) valor_bin <= bin_calc;
  end
`else
  assign valor_bin = '0;
`endif
endmodule
